// File: rtl/wts_mem_arbiter_if.sv
// wts_mem_arbiter bus bundle.
// CPU port, sound fetch port and external memory pins.
interface wts_mem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [20:0] cpu_a;
  logic [7:0]  cpu_d;
  logic [7:0]  cpu_q;
  logic        cpu_ack;
  logic [3:0]  snd_req;
  logic [83:0] snd_a;
  logic [7:0]  snd_q;
  logic [3:0]  snd_ack;
  logic        mem_ncs;
  logic        mem_noe;
  logic        mem_nwe;
  logic [20:0] mem_a;
  logic [7:0]  mem_d_out;
  logic        mem_d_oe;
  logic [7:0]  mem_d_in;

  modport master (
    output cpu_req,
    output cpu_we,
    output cpu_a,
    output cpu_d,
    input  cpu_q,
    input  cpu_ack,
    output snd_req,
    output snd_a,
    input  snd_q,
    input  snd_ack,
    input  mem_ncs,
    input  mem_noe,
    input  mem_nwe,
    input  mem_a,
    input  mem_d_out,
    input  mem_d_oe,
    output mem_d_in
  );

  modport slave (
    input  cpu_req,
    input  cpu_we,
    input  cpu_a,
    input  cpu_d,
    output cpu_q,
    output cpu_ack,
    input  snd_req,
    input  snd_a,
    output snd_q,
    output snd_ack,
    output mem_ncs,
    output mem_noe,
    output mem_nwe,
    output mem_a,
    output mem_d_out,
    output mem_d_oe,
    input  mem_d_in
  );
endinterface

// File: rtl/wts_mem_arbiter.sv
// wts_mem_arbiter: shares one async SRAM between the CPU
// slot port and four sound fetch channels.
module wts_mem_arbiter #(
  parameter int ACCESS_CYCLES   = 3,
  parameter int RECOVERY_CYCLES = 1
) (
  input logic              clk,
  input logic              slot_nreset,
  wts_mem_arbiter_if.slave bus
);

  localparam logic [3:0] ACC_LAST = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] REC_LAST = 4'(RECOVERY_CYCLES - 1);
  localparam logic [3:0] NWE_END  = 4'(ACCESS_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RECOVER
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        pend_q, pend_d;
  logic        we_q, we_d;
  logic [20:0] ca_q, ca_d;
  logic [7:0]  cd_q, cd_d;

  logic        prev_cpu_q, prev_cpu_d;
  logic [1:0]  rr_q, rr_d;
  logic        gnt_cpu_q, gnt_cpu_d;
  logic [1:0]  gnt_ch_q, gnt_ch_d;

  logic        ncs_q, ncs_d;
  logic        noe_q, noe_d;
  logic        nwe_q, nwe_d;
  logic        doe_q, doe_d;
  logic [20:0] ma_q, ma_d;
  logic [7:0]  dout_q, dout_d;
  logic        cack_q, cack_d;
  logic [3:0]  sack_q, sack_d;
  logic [7:0]  cq_q, cq_d;
  logic [7:0]  sq_q, sq_d;

  logic        pick_vld;
  logic [1:0]  pick_ch;
  logic [1:0]  rr_idx;
  logic        arb_go;
  logic        arb_cpu;
  logic        acc_end;
  logic        rec_end;
  logic        cpu_done;
  logic        start;
  logic [20:0] snd_addr [4];

  for (genvar g = 0; g < 4; g++) begin : g_sa
    assign snd_addr[g] = bus.snd_a[21*g +: 21];
  end

  assign acc_end  = (state_q == ACCESS) &&
                    (cnt_q == ACC_LAST);
  assign rec_end  = (state_q == RECOVER) &&
                    (cnt_q == REC_LAST);
  assign cpu_done = acc_end && gnt_cpu_q;

  // Round-robin search starting at the pointer.
  always_comb begin
    pick_vld = 1'b0;
    pick_ch  = 2'd0;
    rr_idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      rr_idx = rr_q + 2'(i);
      if (!pick_vld && bus.snd_req[rr_idx]) begin
        pick_vld = 1'b1;
        pick_ch  = rr_idx;
      end
    end
  end

  // CPU wins unless it won last time and sound waits.
  assign arb_go  = pend_q || pick_vld;
  assign arb_cpu = pend_q && !(prev_cpu_q && pick_vld);
  assign start   = arb_go &&
                   ((state_q == IDLE) || rec_end);

  // Single-entry CPU request latch; extra pulses dropped.
  always_comb begin
    pend_d = pend_q;
    we_d   = we_q;
    ca_d   = ca_q;
    cd_d   = cd_q;
    if (cpu_done) begin
      pend_d = 1'b0;
    end else if (bus.cpu_req && !pend_q) begin
      pend_d = 1'b1;
      we_d   = bus.cpu_we;
      ca_d   = bus.cpu_a;
      cd_d   = bus.cpu_d;
    end
  end

  // Next state and registered strobe values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prev_cpu_d = prev_cpu_q;
    rr_d       = rr_q;
    gnt_cpu_d  = gnt_cpu_q;
    gnt_ch_d   = gnt_ch_q;
    ncs_d      = ncs_q;
    noe_d      = noe_q;
    nwe_d      = nwe_q;
    doe_d      = doe_q;
    ma_d       = ma_q;
    dout_d     = dout_q;
    cack_d     = 1'b0;
    sack_d     = 4'd0;
    cq_d       = cq_q;
    sq_d       = sq_q;

    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      ACCESS: begin
        if (acc_end) begin
          state_d = RECOVER;
          cnt_d   = 4'd0;
          ncs_d   = 1'b1;
          noe_d   = 1'b1;
          nwe_d   = 1'b1;
          doe_d   = 1'b0;
          if (gnt_cpu_q) begin
            cack_d = 1'b1;
            if (!we_q) begin
              cq_d = bus.mem_d_in;
            end
          end else begin
            sack_d = 4'b0001 << gnt_ch_q;
            sq_d   = bus.mem_d_in;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == NWE_END) begin
            nwe_d = 1'b1;
          end
        end
      end
      RECOVER: begin
        if (rec_end) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start) begin
      state_d    = ACCESS;
      cnt_d      = 4'd0;
      ncs_d      = 1'b0;
      gnt_cpu_d  = arb_cpu;
      prev_cpu_d = arb_cpu;
      if (arb_cpu) begin
        ma_d = ca_q;
        if (we_q) begin
          noe_d  = 1'b1;
          nwe_d  = 1'b0;
          doe_d  = 1'b1;
          dout_d = cd_q;
        end else begin
          noe_d = 1'b0;
          nwe_d = 1'b1;
          doe_d = 1'b0;
        end
      end else begin
        gnt_ch_d = pick_ch;
        rr_d     = pick_ch + 2'd1;
        ma_d     = snd_addr[pick_ch];
        noe_d    = 1'b0;
        nwe_d    = 1'b1;
        doe_d    = 1'b0;
      end
    end
  end

  // State and output registers; reset aborts any access.
  always_ff @(posedge clk or negedge slot_nreset) begin
    if (!slot_nreset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      pend_q     <= 1'b0;
      we_q       <= 1'b0;
      ca_q       <= 21'd0;
      cd_q       <= 8'd0;
      prev_cpu_q <= 1'b0;
      rr_q       <= 2'd0;
      gnt_cpu_q  <= 1'b0;
      gnt_ch_q   <= 2'd0;
      ncs_q      <= 1'b1;
      noe_q      <= 1'b1;
      nwe_q      <= 1'b1;
      doe_q      <= 1'b0;
      ma_q       <= 21'd0;
      dout_q     <= 8'd0;
      cack_q     <= 1'b0;
      sack_q     <= 4'd0;
      cq_q       <= 8'd0;
      sq_q       <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      we_q       <= we_d;
      ca_q       <= ca_d;
      cd_q       <= cd_d;
      prev_cpu_q <= prev_cpu_d;
      rr_q       <= rr_d;
      gnt_cpu_q  <= gnt_cpu_d;
      gnt_ch_q   <= gnt_ch_d;
      ncs_q      <= ncs_d;
      noe_q      <= noe_d;
      nwe_q      <= nwe_d;
      doe_q      <= doe_d;
      ma_q       <= ma_d;
      dout_q     <= dout_d;
      cack_q     <= cack_d;
      sack_q     <= sack_d;
      cq_q       <= cq_d;
      sq_q       <= sq_d;
    end
  end

  assign bus.mem_ncs   = ncs_q;
  assign bus.mem_noe   = noe_q;
  assign bus.mem_nwe   = nwe_q;
  assign bus.mem_d_oe  = doe_q;
  assign bus.mem_a     = ma_q;
  assign bus.mem_d_out = dout_q;
  assign bus.cpu_ack   = cack_q;
  assign bus.cpu_q     = cq_q;
  assign bus.snd_ack   = sack_q;
  assign bus.snd_q     = sq_q;

endmodule
